// File: rtl/denoise_pkg.sv
// Shared types and constants for the line-buffer stream controller:
// FSM encoding, row-rotation width and default frame geometry.
package denoise_pkg;

    localparam int LINE_WIDTH_DEF   = 1920;
    localparam int FRAME_HEIGHT_DEF = 1080;
    localparam int X_W              = 11;
    localparam int ROW_W            = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_FLUSH
    } state_e;

    // Physical line buffers rotate 0 -> 1 -> 2 -> 0.
    function automatic logic [ROW_W-1:0] row_next(input logic [ROW_W-1:0] r);
        return (r == ROW_W'(2)) ? '0 : r + ROW_W'(1);
    endfunction

endpackage

// File: rtl/mod3_counter.sv
// Physical write-row selector for the three line buffers. A clear restarts
// at row 0; an enable in the same cycle advances past it.
module mod3_counter
    import denoise_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [ROW_W-1:0] value_o
);

    logic [ROW_W-1:0] value_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value_q <= '0;
        end else if (clr_i) begin
            value_q <= en_i ? ROW_W'(1) : '0;
        end else if (en_i) begin
            value_q <= row_next(value_q);
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/lb_stream_ctrl.sv
// AXI4-Stream video to 3-line-buffer controller: writes incoming pixels,
// issues lagged reads and qualifies 3x3 window centres with line indices.
module lb_stream_ctrl
    import denoise_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int LINE_WIDTH   = LINE_WIDTH_DEF,
    parameter int FRAME_HEIGHT = FRAME_HEIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tuser,
    input  logic                  s_tlast,
    output logic                  en_wr,
    output logic [X_W-1:0]        write_x,
    output logic [ROW_W-1:0]      write_row,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  en_rd,
    output logic [X_W-1:0]        read_x,
    output logic                  win_valid,
    output logic [ROW_W-1:0]      top_row,
    output logic [X_W-1:0]        win_y,
    output logic                  err_sync
);

    localparam logic [X_W-1:0] LAST_X = X_W'(LINE_WIDTH - 1);
    localparam logic [X_W-1:0] LAST_Y = X_W'(FRAME_HEIGHT - 1);

    state_e           state_q, state_d;
    logic [X_W-1:0]   col_q, col_d;
    logic [X_W-1:0]   line_q, line_d;
    logic             err_q, err_d;
    logic             win_valid_q;
    logic [ROW_W-1:0] top_row_q;
    logic [X_W-1:0]   win_y_q;
    logic [ROW_W-1:0] row_cur;
    logic             row_clr, row_en;

    logic             ready, accept, sof, beat, at_last, eol, rd_beat, flush;
    logic [X_W-1:0]   x_eff, line_eff;

    mod3_counter u_row (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (row_clr),
        .en_i    (row_en),
        .value_o (row_cur)
    );

    // A SOF beat always lands at x=0 of line 0, whatever the counters say.
    always_comb begin
        ready    = (state_q != ST_FLUSH);
        accept   = rstn && s_tvalid && ready;
        sof      = accept && s_tuser;
        beat     = accept && ((state_q != ST_IDLE) || s_tuser);
        x_eff    = s_tuser ? '0 : col_q;
        line_eff = s_tuser ? '0 : line_q;
        at_last  = (x_eff == LAST_X);
        eol      = s_tlast || at_last;
        rd_beat  = beat && !s_tuser && (state_q == ST_RUN) && (col_q != '0);
        flush    = (state_q == ST_FLUSH);
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        row_clr = 1'b0;
        row_en  = 1'b0;
        err_d   = err_q || (sof && (state_q != ST_IDLE)) || (beat && (s_tlast != at_last));
        if (flush) begin
            if (line_q == LAST_Y) begin
                state_d = ST_IDLE;
                line_d  = '0;
                row_clr = 1'b1;
            end else begin
                state_d = ST_RUN;
                line_d  = line_q + X_W'(1);
                row_en  = 1'b1;
            end
        end else if (beat) begin
            row_clr = s_tuser;
            if (eol) begin
                col_d = '0;
                if (line_eff < X_W'(2)) begin
                    line_d  = line_eff + X_W'(1);
                    row_en  = 1'b1;
                    state_d = (line_eff == '0) ? ST_PRIME : ST_RUN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end else begin
                col_d   = x_eff + X_W'(1);
                line_d  = line_eff;
                state_d = (line_eff < X_W'(2)) ? ST_PRIME : ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            line_q      <= '0;
            err_q       <= 1'b0;
            win_valid_q <= 1'b0;
            top_row_q   <= '0;
            win_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            err_q       <= err_d;
            win_valid_q <= en_rd;
            if (en_rd) begin
                top_row_q <= row_next(row_cur);
                win_y_q   <= line_q - X_W'(1);
            end
        end
    end

    // Reads trail writes by one column; the flush cycle reads the final column.
    assign s_tready  = ready;
    assign en_wr     = beat;
    assign write_x   = x_eff;
    assign write_row = s_tuser ? '0 : row_cur;
    assign pixel_out = beat ? s_tdata : '0;
    assign en_rd     = rd_beat || flush;
    assign read_x    = flush ? LAST_X : (rd_beat ? col_q - X_W'(1) : '0);
    assign win_valid = win_valid_q;
    assign top_row   = top_row_q;
    assign win_y     = win_y_q;
    assign err_sync  = err_q;

endmodule

// File: tb/tb_lb_stream_ctrl.sv
// Scoreboard bench for lb_stream_ctrl: a frame-level model predicts writes,
// reads and windows per beat; a negedge monitor pops and compares them.
module tb_lb_stream_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
    logic          s_tready, en_wr, en_rd, win_valid, err_sync;
    logic [10:0]   write_x, read_x, win_y;
    logic [1:0]    write_row, top_row;
    logic [DW-1:0] pixel_out;

    always #5 clk = ~clk;

    lb_stream_ctrl #(.DATA_WIDTH(DW), .LINE_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk(clk), .rstn(rstn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .en_wr(en_wr), .write_x(write_x), .write_row(write_row), .pixel_out(pixel_out),
        .en_rd(en_rd), .read_x(read_x),
        .win_valid(win_valid), .top_row(top_row), .win_y(win_y),
        .err_sync(err_sync)
    );

    typedef struct { int x; int row; logic [31:0] data; } wr_exp_t;
    typedef struct { int top; int y; } win_exp_t;

    wr_exp_t  wr_q[$];
    int       rd_q[$];
    win_exp_t win_q[$];
    wr_exp_t  mon_wr;
    win_exp_t mon_win;
    int       mon_rd;

    int checks = 0;
    int errors = 0;
    int win_count = 0;

    bit m_active, m_err;
    int m_x, m_line;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame geometry from the stream rules, row = line mod 3.
    task automatic model_beat(input logic [31:0] data, input bit user, input bit last);
        bit eol;
        if (!m_active && !user) return;
        if (user) begin
            if (m_active) m_err = 1;
            m_active = 1;
            m_x = 0;
            m_line = 0;
        end
        wr_q.push_back('{m_x, m_line % 3, data});
        if (m_line >= 2 && m_x >= 1) begin
            rd_q.push_back(m_x - 1);
            win_q.push_back('{(m_line - 2) % 3, m_line - 1});
        end
        eol = last || (m_x == W - 1);
        if (last != (m_x == W - 1)) m_err = 1;
        if (eol) begin
            if (m_line >= 2) begin
                rd_q.push_back(W - 1);
                win_q.push_back('{(m_line - 2) % 3, m_line - 1});
            end
            m_line++;
            m_x = 0;
            if (m_line == H) begin
                m_active = 0;
                m_line = 0;
            end
        end else begin
            m_x++;
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (en_wr) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_en_wr: write_x %0d, none expected", write_x);
                end else begin
                    mon_wr = wr_q.pop_front();
                    check("write_x", 32'(write_x), mon_wr.x);
                    check("write_row", 32'(write_row), mon_wr.row);
                    check("pixel_out", pixel_out, mon_wr.data);
                end
            end
            if (en_rd) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_en_rd: read_x %0d, none expected", read_x);
                end else begin
                    mon_rd = rd_q.pop_front();
                    check("read_x", 32'(read_x), mon_rd);
                end
            end
            if (win_valid) begin
                win_count++;
                if (win_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_win_valid: win_y %0d, none expected", win_y);
                end else begin
                    mon_win = win_q.pop_front();
                    check("top_row", 32'(top_row), mon_win.top);
                    check("win_y", 32'(win_y), mon_win.y);
                end
            end
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_en_wr", en_wr, 0);
        check("rst_en_rd", en_rd, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_err_sync", err_sync, 0);
        check("rst_write_x", 32'(write_x), 0);
        check("rst_read_x", 32'(read_x), 0);
        check("rst_write_row", 32'(write_row), 0);
        check("rst_top_row", 32'(top_row), 0);
        check("rst_win_y", 32'(win_y), 0);
        check("rst_pixel_out", pixel_out, 0);
        check("rst_s_tready", s_tready, 1);
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        wr_q.delete(); rd_q.delete(); win_q.delete();
        m_active = 0; m_err = 0; m_x = 0; m_line = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic send_beat(input bit user, input bit last, input bit gaps);
        logic [31:0] data;
        int waited;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
        end
        data = $urandom;
        model_beat(data, user, last);
        s_tvalid = 1'b1; s_tdata = data; s_tuser = user; s_tlast = last;
        waited = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            waited++;
            if (waited > 20) begin
                errors++;
                $display("FAIL tready_timeout: s_tready still %0b after %0d cycles", s_tready, waited);
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send_line(input int n, input int last_col, input bit sof, input bit gaps);
        for (int x = 0; x < n; x++) send_beat(sof && x == 0, x == last_col, gaps);
    endtask

    task automatic send_frame(input bit gaps, input bit flush_probe);
        for (int ln = 0; ln < H; ln++) begin
            send_line(W, W - 1, ln == 0, gaps);
            if (flush_probe && ln == 2) begin
                check("flush_s_tready", s_tready, 0);
                check("flush_en_rd", en_rd, 1);
                check("flush_read_x", 32'(read_x), W - 1);
                @(posedge clk); #1;
                check("flush_win_valid", win_valid, 1);
            end
        end
    endtask

    task automatic end_scenario(input string tag);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_wr_left"}, wr_q.size(), 0);
        check({tag, "_rd_left"}, rd_q.size(), 0);
        check({tag, "_win_left"}, win_q.size(), 0);
        check({tag, "_err_sync"}, err_sync, m_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        win_count = 0;
        send_frame(1'b0, 1'b1);
        end_scenario("continuous");
        check("continuous_windows", win_count, 16);

        win_count = 0;
        send_frame(1'b1, 1'b0);
        end_scenario("gapped");
        check("gapped_windows", win_count, 16);

        for (int f = 0; f < 3; f++) send_frame(1'b1, 1'b0);
        end_scenario("random_frames");

        // Early tlast on line 1, then a line missing its tlast.
        do_reset();
        send_line(W, W - 1, 1, 0);
        send_line(6, 5, 0, 0);
        send_line(W, W - 1, 0, 1);
        send_line(W, -1, 0, 1);
        end_scenario("tlast_err");
        check("tlast_err_flag", err_sync, 1);

        // SOF arriving mid-line restarts the frame.
        do_reset();
        win_count = 0;
        send_line(W, W - 1, 1, 0);
        send_line(W, W - 1, 0, 0);
        send_line(3, -1, 0, 0);
        send_frame(1'b1, 1'b0);
        end_scenario("sof_err");
        check("sof_err_flag", err_sync, 1);
        check("sof_err_windows", win_count, 2 + 16);

        // Reset mid-line 3 with a beat on the bus, then headless beats.
        do_reset();
        send_line(W, W - 1, 1, 0);
        send_line(W, W - 1, 0, 0);
        send_line(W, W - 1, 0, 0);
        send_line(4, -1, 0, 0);
        s_tvalid = 1'b1; s_tdata = $urandom; s_tuser = 1'b0; s_tlast = 1'b0;
        #2;
        do_reset();
        for (int i = 0; i < 5; i++) send_beat(0, 0, 0);
        win_count = 0;
        send_frame(1'b1, 1'b0);
        end_scenario("mid_reset");
        check("mid_reset_windows", win_count, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lb_stream_ctrl.md
LB_STREAM_CTRL -- requirements
Module: lb_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel word width.
REQ-002 SHALL have parameter LINE_WIDTH, default 1920, pixels per line (max 2047).
REQ-003 SHALL have parameter FRAME_HEIGHT, default 1080, lines per frame.
REQ-004 SHALL have port clk  input  1  single clock; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports s_tdata/s_tvalid/s_tready/s_tuser/s_tlast  in/in/out/in/in  DATA_WIDTH/1/1/1/1  AXI4-Stream video input; tuser=SOF, tlast=EOL.
REQ-007 SHALL have ports en_wr, write_x[10:0], write_row[1:0], pixel_out[DATA_WIDTH-1:0]  output  line-buffer write side.
REQ-008 SHALL have ports en_rd, read_x[10:0]  output  line-buffer read side.
REQ-009 SHALL have ports win_valid  output 1, top_row[1:0]  output 2, win_y[10:0]  output 11  window qualifier, physical line holding top window row, window centre line index.
REQ-010 SHALL have port err_sync  output 1  sticky framing-error flag, cleared only by reset.

Function
REQ-011 SHALL implement states IDLE, PRIME, RUN, FLUSH.
REQ-012 IDLE: s_tready=1, beats without tuser dropped; beat with tuser and tvalid -> written as x=0 of line 0, go PRIME.
REQ-013 Accepted beat (tvalid&tready) SHALL assert en_wr same cycle, pixel_out=s_tdata, write_x=column counter, write_row=physical write line.
REQ-014 Column counter SHALL increment per accepted beat, return to 0 after tlast; write_row SHALL rotate 0->1->2->0 at each line end.
REQ-015 PRIME: lines 0 and 1 written, no en_rd; on tlast of line 1 go RUN.
REQ-016 RUN: accepted beat at column x>=1 SHALL assert en_rd with read_x=x-1 the same cycle.
REQ-017 On tlast in RUN SHALL go FLUSH; FLUSH holds s_tready=0 one cycle, asserts en_rd with read_x=LINE_WIDTH-1, then RUN (or IDLE after last frame line).
REQ-018 win_valid SHALL assert exactly one cycle after each en_rd (BRAM read latency); exactly LINE_WIDTH windows per line from line 2 on.
REQ-019 top_row SHALL equal physical line holding line y-2, win_y=y-1 where y is the line being written; both registered aligned with win_valid.
REQ-020 Frame SHALL end after FRAME_HEIGHT lines' tlast plus its FLUSH -> IDLE; top/bottom border lines produce no windows.
REQ-021 tlast at column != LINE_WIDTH-1, or no tlast at column LINE_WIDTH-1, SHALL set err_sync and treat beat as line end.
REQ-022 tuser outside IDLE SHALL set err_sync, reset counters, treat beat as x=0 of line 0, go PRIME.
REQ-023 Backpressure: tvalid low SHALL stall all counters; no en_wr/en_rd in stalled cycles except FLUSH.

Reset
REQ-024 On rstn low SHALL asynchronously force IDLE, counters=0, write_row=0, en_wr=en_rd=win_valid=err_sync=0, write_x=read_x=0, top_row=0, win_y=0, pixel_out=0.
REQ-025 Reset mid-frame SHALL discard the frame; first window after release only after new SOF plus two full lines.

Structure
REQ-026 State encoding and row-rotate width SHALL live in shared package denoise_pkg, with LINE_WIDTH/FRAME_HEIGHT defaults.
REQ-027 Row rotation SHALL be sub-module mod3_counter (enable, 2-bit value, wraps 2->0); all else flat.

Verification
REQ-028 LINE_WIDTH=8, FRAME_HEIGHT=4, continuous 32-beat frame -> 16 win_valid pulses, win_y 1 then 2, top_row 0 then 1.
REQ-029 Random tvalid gaps (50%) same frame -> identical window sequence and read_x order 0..7, no extra en_rd.
REQ-030 tlast at column 5 of line 1 -> err_sync=1, next beat write_x=0, write_row=2.
REQ-031 tuser asserted at line 2 column 3 -> err_sync=1, write_row=0, write_x=0, state PRIME, no win_valid for two lines.
REQ-032 rstn pulse at line 3 column 4 -> all outputs 0 within same cycle, beats ignored until tuser.
REQ-033 FLUSH cycle check: after tlast on line 2, next cycle s_tready=0, en_rd=1, read_x=7; following cycle win_valid=1.
